// File: rtl/song_reader_pkg.sv
// Shared definitions for the song player: field widths, ROM geometry and the
// song reader state encoding. The note player and MCU import the same package.
package song_pkg;

  localparam int NOTE_WIDTH     = 6;
  localparam int DURATION_WIDTH = 6;
  localparam int SONG_WIDTH     = 2;
  localparam int INDEX_WIDTH    = 5;
  localparam int NOTES_PER_SONG = 2 ** INDEX_WIDTH;

  localparam int ADDR_WIDTH  = SONG_WIDTH + INDEX_WIDTH;
  localparam int ENTRY_WIDTH = NOTE_WIDTH + DURATION_WIDTH;

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NOTES_PER_SONG - 1);

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_WAIT_ROM  = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_NOTE = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_END       = 3'd5;

  typedef enum logic [2:0] {
    FETCH     = ST_FETCH,
    WAIT_ROM  = ST_WAIT_ROM,
    ISSUE     = ST_ISSUE,
    WAIT_NOTE = ST_WAIT_NOTE,
    DONE      = ST_DONE,
    END       = ST_END
  } state_t;

  // A zero duration terminates a song early; the note field is don't-care.
  function automatic logic isEndMarker(input logic [ENTRY_WIDTH-1:0] entry);
    return entry[DURATION_WIDTH-1:0] == '0;
  endfunction

endpackage

// File: rtl/song_reader_if.sv
// Control bundle around the song reader: MCU play controls and the note
// player handshake. The reader is the slave; the MCU/player side is the master.
interface song_reader_if;
  import song_pkg::*;

  logic                      play;
  logic [SONG_WIDTH-1:0]     song;
  logic                      reset_player;
  logic                      note_done;
  logic [NOTE_WIDTH-1:0]     note;
  logic [DURATION_WIDTH-1:0] duration;
  logic                      new_note;
  logic                      song_done;

  modport master (
    output play, song, reset_player, note_done,
    input  note, duration, new_note, song_done
  );

  modport slave (
    input  play, song, reset_player, note_done,
    output note, duration, new_note, song_done
  );

endinterface

// File: rtl/song_reader_rom.sv
// Song ROM: 4 songs x 32 entries of {note, duration}, synchronous read with
// one cycle of latency. Contents are produced by a constant function so the
// table reads as musical phrases rather than a wall of hex.
module song_rom
  import song_pkg::*;
(
  input  logic                   clk,
  input  logic [ADDR_WIDTH-1:0]  addr,
  output logic [ENTRY_WIDTH-1:0] dout
);

  function automatic logic [ENTRY_WIDTH-1:0] romEntry(input logic [ADDR_WIDTH-1:0] a);
    logic [SONG_WIDTH-1:0]     s;
    logic [INDEX_WIDTH-1:0]    k;
    logic [NOTE_WIDTH-1:0]     n;
    logic [DURATION_WIDTH-1:0] d;
    s = a[ADDR_WIDTH-1:INDEX_WIDTH];
    k = a[INDEX_WIDTH-1:0];
    n = '0;
    d = '0;
    case (s)
      2'd0: begin
        // Short song: two intro notes, a rising run, end marker at entry 10.
        if (k == 5'd0) begin
          n = 6'd20;
          d = 6'd10;
        end else if (k == 5'd1) begin
          n = 6'd25;
          d = 6'd5;
        end else if (k <= 5'd9) begin
          n = 6'(k) + 6'd10;
          d = 6'(k);
        end else if (k == 5'd10) begin
          n = '0;
          d = '0;
        end else begin
          n = 6'(k);
          d = 6'd1;
        end
      end
      2'd1: begin
        // Full-length song, every entry playable.
        n = 6'd32 + 6'(k);
        d = 6'(k) + 6'd1;
      end
      2'd2: begin
        // Three notes then an end marker.
        if (k <= 5'd2) begin
          n = 6'd40 + 6'(k);
          d = 6'd3 + 6'(k);
        end else if (k == 5'd3) begin
          n = '0;
          d = '0;
        end else begin
          n = 6'(k);
          d = 6'd7;
        end
      end
      default: begin
        // Full-length descending song with odd durations.
        n = 6'd63 - 6'(k);
        d = {k, 1'b1};
      end
    endcase
    return {n, d};
  endfunction

  // Registered read port; address presented in one cycle, data the next.
  always_ff @(posedge clk) begin
    dout <= romEntry(addr);
  end

endmodule

// File: rtl/song_reader.sv
// Song reader: walks the note list of the selected song, hands one note at a
// time to the note player and flags the end of the song to the MCU.
module song_reader
  import song_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  song_reader_if.slave bus
);

  state_t                    r_state;
  state_t                    w_nextState;
  logic [INDEX_WIDTH-1:0]    r_idx;
  logic [INDEX_WIDTH-1:0]    w_nextIdx;
  logic [NOTE_WIDTH-1:0]     r_note;
  logic [NOTE_WIDTH-1:0]     w_nextNote;
  logic [DURATION_WIDTH-1:0] r_duration;
  logic [DURATION_WIDTH-1:0] w_nextDuration;

  logic [ADDR_WIDTH-1:0]     w_romAddr;
  logic [ENTRY_WIDTH-1:0]    w_romData;
  logic [NOTE_WIDTH-1:0]     w_romNote;
  logic [DURATION_WIDTH-1:0] w_romDuration;

  // The ROM address follows idx directly, so data stays valid while paused.
  assign w_romAddr = {bus.song, r_idx};

  song_rom u_rom (
    .clk  (clk),
    .addr (w_romAddr),
    .dout (w_romData)
  );

  assign {w_romNote, w_romDuration} = w_romData;

  // State, note index and the current note registers, cleared by async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= FETCH;
      r_idx      <= '0;
      r_note     <= '0;
      r_duration <= '0;
    end else begin
      r_state    <= w_nextState;
      r_idx      <= w_nextIdx;
      r_note     <= w_nextNote;
      r_duration <= w_nextDuration;
    end
  end

  // Next-state logic; a player restart overrides every transition, and a
  // low play level freezes the fetch/issue path but never the note_done wait.
  always_comb begin
    w_nextState    = r_state;
    w_nextIdx      = r_idx;
    w_nextNote     = r_note;
    w_nextDuration = r_duration;
    if (bus.reset_player) begin
      w_nextState    = FETCH;
      w_nextIdx      = '0;
      w_nextNote     = '0;
      w_nextDuration = '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (bus.play) begin
            w_nextState = WAIT_ROM;
          end
        end
        WAIT_ROM: begin
          if (bus.play) begin
            if (isEndMarker(w_romData)) begin
              w_nextState = DONE;
            end else begin
              w_nextNote     = w_romNote;
              w_nextDuration = w_romDuration;
              w_nextState    = ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.play) begin
            w_nextState = WAIT_NOTE;
          end
        end
        WAIT_NOTE: begin
          if (bus.note_done) begin
            if (r_idx == LAST_INDEX) begin
              w_nextState = DONE;
            end else begin
              w_nextIdx   = r_idx + INDEX_WIDTH'(1);
              w_nextState = FETCH;
            end
          end
        end
        DONE: begin
          w_nextState = END;
        end
        END: begin
          w_nextState = END;
        end
        default: begin
          w_nextState = FETCH;
        end
      endcase
    end
  end

  assign bus.new_note  = (r_state == ISSUE) && bus.play;
  assign bus.song_done = (r_state == DONE);
  assign bus.note      = r_note;
  assign bus.duration  = r_duration;

endmodule

// File: tb/tb_song_reader.sv
// Testbench for song_reader: directed timing sequences, a table of expected
// ROM notes per song position, and a randomized run against a note-list model.
module tb_song_reader;
  import song_pkg::*;

  logic clk = 1'b0;
  logic reset;

  song_reader_if bus ();

  song_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] song;
    int         idx;
    int         expNote;
    int         expDur;
  } vec_t;

  vec_t vecs[10];

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the clock edge, then settle for sampling.
  task automatic applyStimulus(input logic p, input logic [1:0] s, input logic rp, input logic nd);
    @(posedge clk);
    #1;
    bus.play         = p;
    bus.song         = s;
    bus.reset_player = rp;
    bus.note_done    = nd;
    #1;
  endtask

  // Play on until a new_note strobe appears or the cycle budget runs out.
  task automatic waitNewNote(input logic [1:0] s, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      applyStimulus(1'b1, s, 1'b0, 1'b0);
      if (bus.new_note === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  // Restart song s and play it up to entry target, answering every note.
  task automatic runToNote(input logic [1:0] s, input int target, output int n, output int d);
    bit seen;
    n = -1;
    d = -1;
    applyStimulus(1'b1, s, 1'b1, 1'b0);
    for (int k = 0; k <= target; k++) begin
      waitNewNote(s, 10, seen);
      if (!seen) begin
        checkOutput("runToNote timeout", 0, 1);
        return;
      end
      if (k == target) begin
        n = int'(bus.note);
        d = int'(bus.duration);
      end else begin
        applyStimulus(1'b1, s, 1'b0, 1'b1);
      end
    end
  endtask

  // Reference song contents, written from the musical description of each song.
  function automatic logic [11:0] refEntry(input int s, input int k);
    int n;
    int d;
    if (s == 0) begin
      if (k == 0) begin n = 20; d = 10; end
      else if (k == 1) begin n = 25; d = 5; end
      else if (k < 10) begin n = k + 10; d = k; end
      else if (k == 10) begin n = 0; d = 0; end
      else begin n = k; d = 1; end
    end else if (s == 1) begin
      n = 32 + k;
      d = k + 1;
    end else if (s == 2) begin
      if (k < 3) begin n = 40 + k; d = 3 + k; end
      else if (k == 3) begin n = 0; d = 0; end
      else begin n = k; d = 7; end
    end else begin
      n = 63 - k;
      d = 2 * k + 1;
    end
    return {n[5:0], d[5:0]};
  endfunction

  // Number of playable notes before the end marker (or the whole song).
  function automatic int songLength(input int s);
    logic [11:0] e;
    for (int k = 0; k < 32; k++) begin
      e = refEntry(s, k);
      if (e[5:0] == 6'd0) return k;
    end
    return 32;
  endfunction

  initial begin
    bit          seen;
    int          nNotes;
    int          strays;
    int          n;
    int          d;
    int          s;
    int          k;
    int          cnt;
    int          len;
    int          phase;
    int          nextPhase;
    int          expNew;
    int          expDone;
    logic        p;
    logic        rp;
    logic        nd;
    logic [1:0]  newSong;
    logic [11:0] e;

    vecs[0] = '{2'd0, 0, 20, 10};
    vecs[1] = '{2'd0, 1, 25, 5};
    vecs[2] = '{2'd0, 5, 15, 5};
    vecs[3] = '{2'd1, 0, 32, 1};
    vecs[4] = '{2'd1, 17, 49, 18};
    vecs[5] = '{2'd1, 31, 63, 32};
    vecs[6] = '{2'd2, 2, 42, 5};
    vecs[7] = '{2'd3, 0, 63, 1};
    vecs[8] = '{2'd3, 10, 53, 21};
    vecs[9] = '{2'd3, 31, 32, 63};

    bus.play         = 1'b0;
    bus.song         = 2'd0;
    bus.reset_player = 1'b0;
    bus.note_done    = 1'b0;
    reset            = 1'b1;

    // Reset state, with play already high
    repeat (3) applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("reset new_note", 32'(bus.new_note), 0);
    checkOutput("reset song_done", 32'(bus.song_done), 0);
    checkOutput("reset note", 32'(bus.note), 0);
    checkOutput("reset duration", 32'(bus.duration), 0);
    checkOutput("reset idx", 32'(dut.r_idx), 0);

    // First note two cycles after reset release
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.play = 1'b1;
    #1;
    checkOutput("release c0 new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("release c1 new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("release c2 new_note", 32'(bus.new_note), 1);
    checkOutput("first note", 32'(bus.note), 20);
    checkOutput("first duration", 32'(bus.duration), 10);

    // note_done -> next strobe exactly three cycles later
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("next u+1 new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("next u+2 new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("next u+3 new_note", 32'(bus.new_note), 1);
    checkOutput("second note", 32'(bus.note), 25);
    checkOutput("second duration", 32'(bus.duration), 5);
    checkOutput("second idx", 32'(dut.r_idx), 1);

    // Table of song positions and the note each must carry
    foreach (vecs[i]) begin
      runToNote(vecs[i].song, vecs[i].idx, n, d);
      checkOutput($sformatf("table%0d note", i), 32'(n), 32'(vecs[i].expNote));
      checkOutput($sformatf("table%0d duration", i), 32'(d), 32'(vecs[i].expDur));
    end

    // Full song 1: 32 notes, song_done one cycle after the last note_done
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
    nNotes = 0;
    for (int i = 0; i < 32; i++) begin
      waitNewNote(2'd1, 10, seen);
      if (!seen) break;
      nNotes++;
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
    end
    checkOutput("song1 note count", 32'(nNotes), 32);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    checkOutput("song1 song_done u+1", 32'(bus.song_done), 1);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    checkOutput("song1 song_done u+2", 32'(bus.song_done), 0);
    strays = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 2'd1, 1'b0, logic'(i % 2));
      if (bus.new_note !== 1'b0 || bus.song_done !== 1'b0) strays++;
    end
    checkOutput("song1 END quiet", 32'(strays), 0);

    // Song 2: three notes, end marker, song_done with restart in the same cycle
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    nNotes = 0;
    for (int i = 0; i < 3; i++) begin
      waitNewNote(2'd2, 10, seen);
      if (!seen) break;
      nNotes++;
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
    end
    checkOutput("song2 note count", 32'(nNotes), 3);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    checkOutput("song2 u+1 song_done", 32'(bus.song_done), 0);
    checkOutput("song2 u+1 new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    checkOutput("song2 u+2 song_done", 32'(bus.song_done), 0);
    checkOutput("song2 u+2 new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    checkOutput("song2 u+3 song_done", 32'(bus.song_done), 1);
    checkOutput("song2 u+3 new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("restart r+1 song_done", 32'(bus.song_done), 0);
    checkOutput("restart r+1 idx", 32'(dut.r_idx), 0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("restart r+2 new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("restart r+3 new_note", 32'(bus.new_note), 1);
    checkOutput("restart song3 note", 32'(bus.note), 63);
    checkOutput("restart song3 duration", 32'(bus.duration), 1);

    // Pause in ISSUE for five cycles, then note_done taken while paused
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
      checkOutput($sformatf("pause%0d new_note", i), 32'(bus.new_note), 0);
    end
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("unpause new_note", 32'(bus.new_note), 1);
    checkOutput("unpause note", 32'(bus.note), 20);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("paused note_done idx", 32'(dut.r_idx), 1);
    checkOutput("paused note held", 32'(bus.note), 20);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("paused FETCH new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("resume new_note", 32'(bus.new_note), 1);
    checkOutput("resume note", 32'(bus.note), 25);
    checkOutput("resume duration", 32'(bus.duration), 5);

    // reset_player at idx 7, then again during an ISSUE cycle
    runToNote(2'd0, 7, n, d);
    checkOutput("idx7 note", 32'(n), 17);
    checkOutput("idx7 duration", 32'(d), 7);
    checkOutput("idx7 idx", 32'(dut.r_idx), 7);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("rp idx", 32'(dut.r_idx), 0);
    checkOutput("rp note", 32'(bus.note), 0);
    checkOutput("rp duration", 32'(bus.duration), 0);
    checkOutput("rp new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("rp r+2 new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    checkOutput("rp in ISSUE new_note", 32'(bus.new_note), 1);
    checkOutput("rp in ISSUE note", 32'(bus.note), 20);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("rp ISSUE r+1 new_note", 32'(bus.new_note), 0);
    checkOutput("rp ISSUE r+1 note", 32'(bus.note), 0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("rp ISSUE r+3 new_note", 32'(bus.new_note), 1);
    checkOutput("rp ISSUE r+3 note", 32'(bus.note), 20);
    checkOutput("rp ISSUE r+3 duration", 32'(bus.duration), 10);

    // Async reset in the middle of a note
    runToNote(2'd3, 4, n, d);
    checkOutput("song3 idx4 note", 32'(n), 59);
    checkOutput("song3 idx4 duration", 32'(d), 9);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("async note", 32'(bus.note), 0);
    checkOutput("async duration", 32'(bus.duration), 0);
    checkOutput("async idx", 32'(dut.r_idx), 0);
    checkOutput("async new_note", 32'(bus.new_note), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async c0 new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("async c1 new_note", 32'(bus.new_note), 0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("async c2 new_note", 32'(bus.new_note), 1);
    checkOutput("async c2 note", 32'(bus.note), 63);
    checkOutput("async c2 duration", 32'(bus.duration), 1);

    // Randomized play/note_done/restart traffic against the note-list model.
    // phase: 0 fetching (counts play-high cycles), 1 waiting for note_done,
    // 2 song_done due this cycle, 3 song over.
    s = int'($urandom_range(0, 3));
    applyStimulus(1'b1, 2'(s), 1'b1, 1'b0);
    len   = songLength(s);
    k     = 0;
    cnt   = 0;
    phase = 0;
    for (int c = 0; c < 6000; c++) begin
      p  = ($urandom_range(0, 9) < 8);
      nd = ($urandom_range(0, 2) == 0);
      if (phase == 3) rp = ($urandom_range(0, 9) == 0);
      else            rp = ($urandom_range(0, 999) < 3);
      newSong = rp ? 2'($urandom_range(0, 3)) : 2'(s);
      applyStimulus(p, newSong, rp, nd);

      expNew    = 0;
      expDone   = 0;
      nextPhase = phase;
      case (phase)
        0: begin
          if (p) begin
            cnt++;
            if (k == len) begin
              if (cnt == 2) nextPhase = 2;
            end else if (cnt == 3) begin
              expNew    = 1;
              nextPhase = 1;
            end
          end
        end
        1: begin
          if (nd) begin
            if (k == 31) begin
              nextPhase = 2;
            end else begin
              k++;
              cnt       = 0;
              nextPhase = 0;
            end
          end
        end
        2: begin
          expDone   = 1;
          nextPhase = 3;
        end
        default: ;
      endcase

      checkOutput($sformatf("rand c%0d new_note", c), 32'(bus.new_note), 32'(expNew));
      checkOutput($sformatf("rand c%0d song_done", c), 32'(bus.song_done), 32'(expDone));
      if (expNew == 1 && bus.new_note === 1'b1) begin
        e = refEntry(s, k);
        checkOutput($sformatf("rand c%0d note", c), 32'(bus.note), 32'(e[11:6]));
        checkOutput($sformatf("rand c%0d duration", c), 32'(bus.duration), 32'(e[5:0]));
      end

      if (rp) begin
        s         = int'(newSong);
        len       = songLength(s);
        k         = 0;
        cnt       = 0;
        nextPhase = 0;
      end
      phase = nextPhase;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
